// File: rtl/crc16_serial.sv
// crc16_serial: bit-serial CRC-16/CCITT (poly 0x1021, init 0xFFFF).
// Optional final XOR of the result with 0xFFFF under CRC16_FINAL_XOR_EN.
module crc16_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] in,
  output logic        ready,
  output logic [15:0] out
);

  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] INIT = 16'hFFFF;
`ifdef CRC16_FINAL_XOR_EN
  localparam logic [15:0] FXOR = 16'hFFFF;
`else
  localparam logic [15:0] FXOR = 16'h0000;
`endif
  localparam logic [15:0] RES_INIT = INIT ^ FXOR;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [15:0] crc_q, crc_d;
  logic [15:0] sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:0]  state_q, state_d;
  logic [15:0] res_q, res_d;
  logic        fb;
  logic [15:0] crc_nx;

  // One LFSR step: feedback is the XOR of the CRC and data MSBs.
  always_comb begin
    fb     = crc_q[15] ^ sh_q[15];
    crc_nx = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  end

  // Next-state: clear aborts any word; IDLE accepts, SHIFT folds bits.
  always_comb begin
    crc_d   = crc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    res_d   = res_q;
    if (clear) begin
      crc_d   = INIT;
      cnt_d   = 4'd0;
      state_d = S_IDLE;
      res_d   = RES_INIT;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (load) begin
            sh_d    = in;
            cnt_d   = 4'd0;
            state_d = S_SHIFT;
          end
        end
        (state_q == S_SHIFT): begin
          crc_d = crc_nx;
          sh_d  = {sh_q[14:0], 1'b0};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            res_d   = crc_nx ^ FXOR;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q   <= INIT;
      sh_q    <= 16'h0000;
      cnt_q   <= 4'd0;
      state_q <= S_IDLE;
      res_q   <= RES_INIT;
    end else begin
      crc_q   <= crc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign out   = res_q;

endmodule
